// File: rtl/olimp_lane_acc_if.sv
// olimp_lane_acc_if: beat input, MAC partial sums and result FIFO handshake for olimp_lane_acc
interface olimp_lane_acc_if #(
  parameter int CNT_W = 16
);
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic [31:0] acc0;
  logic [31:0] acc1;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_acc0;
  logic [31:0] out_acc1;
  logic [CNT_W-1:0] out_cnt;
  logic [1:0] out_sat;
  modport master (
    output in_valid, in_last, acc0, acc1, out_ready,
    input in_ready, out_valid, out_acc0, out_acc1, out_cnt, out_sat
  );
  modport slave (
    input in_valid, in_last, acc0, acc1, out_ready,
    output in_ready, out_valid, out_acc0, out_acc1, out_cnt, out_sat
  );
endinterface

// File: rtl/olimp_lane_acc.sv
// olimp_lane_acc: accumulates MAC lane-pair sums per packet into a credit-gated result FIFO; OLIMP_LANE_ACC_SAT_EN enables per-lane saturation
module olimp_lane_acc #(
  parameter int MAC_LAT = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic clk_dsp,
  input logic rst,
  olimp_lane_acc_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [MAC_LAT-1:0] pv, pl;
  logic live;
  logic [CW-1:0] fcnt;
  logic [AW-1:0] rp, wp;
  logic [31:0] m0 [FIFO_DEPTH];
  logic [31:0] m1 [FIFO_DEPTH];
  logic [CNT_W-1:0] mc [FIFO_DEPTH];
  logic [1:0] ms [FIFO_DEPTH];
  logic [31:0] run0, run1, r0, r1, credit;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0] satf, ovf;
  logic take, dv, push, pop;

  assign take = bus.in_valid && bus.in_ready;
  assign dv = pv[MAC_LAT-1];
  assign push = dv && pl[MAC_LAT-1];
  assign pop = bus.out_valid && bus.out_ready;
  assign credit = 32'(fcnt) + 32'($countones(pl));
  assign bus.in_ready = live && !rst && credit < 32'(FIFO_DEPTH);
  assign cnt_nx = &cnt ? cnt : cnt + CNT_W'(1);

`ifdef OLIMP_LANE_ACC_SAT_EN
  logic [32:0] s0, s1;
  assign s0 = {run0[31], run0} + {bus.acc0[31], bus.acc0};
  assign s1 = {run1[31], run1} + {bus.acc1[31], bus.acc1};
  assign ovf = {s1[32] != s1[31], s0[32] != s0[31]};
  assign r0 = ovf[0] ? (s0[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s0[31:0];
  assign r1 = ovf[1] ? (s1[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s1[31:0];
`else
  assign ovf = 2'b00;
  assign r0 = run0 + bus.acc0;
  assign r1 = run1 + bus.acc1;
`endif

  assign bus.out_valid = fcnt != '0;
  assign bus.out_acc0 = bus.out_valid ? m0[rp] : '0;
  assign bus.out_acc1 = bus.out_valid ? m1[rp] : '0;
  assign bus.out_cnt = bus.out_valid ? mc[rp] : '0;
  assign bus.out_sat = bus.out_valid ? ms[rp] : '0;

  // {valid,last} delay pipe aligning accepted beats with MAC output, plus post-reset ready enable
  always_ff @(posedge clk_dsp) begin
    if (rst) begin
      pv <= '0;
      pl <= '0;
      live <= 1'b0;
    end else begin
      pv <= MAC_LAT'({pv, take});
      pl <= MAC_LAT'({pl, take && bus.in_last});
      live <= 1'b1;
    end
  end

  // per-packet running sums, beat counter and sticky saturation flags
  always_ff @(posedge clk_dsp) begin
    if (rst || push) begin
      run0 <= '0;
      run1 <= '0;
      cnt <= '0;
      satf <= '0;
    end else if (dv) begin
      run0 <= r0;
      run1 <= r1;
      cnt <= cnt_nx;
      satf <= satf | ovf;
    end
  end

  // result FIFO with registered head; push and pop may coincide
  always_ff @(posedge clk_dsp) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      fcnt <= '0;
    end else begin
      if (push) begin
        m0[wp] <= r0;
        m1[wp] <= r1;
        mc[wp] <= cnt_nx;
        ms[wp] <= satf | ovf;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      fcnt <= fcnt + CW'(push) - CW'(pop);
    end
  end

  // credit accounting must never let a finished packet meet a full FIFO without a pop
  always_ff @(posedge clk_dsp) begin
    if (!rst) assert (!(push && fcnt == CW'(FIFO_DEPTH) && !pop));
  end
endmodule

// File: tb/tb_olimp_lane_acc.sv
// tb_olimp_lane_acc: randomized and directed bench for olimp_lane_acc against a packet-level model
module tb_olimp_lane_acc;
  localparam int MAC_LAT = 3;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  typedef struct {int due; logic [31:0] a0; logic [31:0] a1;} mac_t;
  typedef struct {int due; bit last;} beat_t;
  typedef struct {logic [31:0] a0; logic [31:0] a1; int c; int s;} ent_t;

  logic clk = 0;
  logic rst = 1;
  int tcyc = 0;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  bit rst_prev = 1;

  mac_t macq[$];
  beat_t bq[$];
  ent_t eq[$];
  ent_t got[$];
  int run0, run1, mcnt, msat, pend;
  longint s0, s1;
  bit e_rdy;

  olimp_lane_acc_if #(.CNT_W(CNT_W)) bus ();

  olimp_lane_acc #(.MAC_LAT(MAC_LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_dsp(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, tcyc);
    end
  endfunction

  function automatic logic [31:0] rnd();
    return $urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(0, 200)) - 32'd100;
  endfunction

  // MAC stand-in: scheduled partial sums on their due cycle, garbage otherwise
  always @(posedge clk) begin
    #1;
    if (macq.size() != 0 && macq[0].due == tcyc) begin
      bus.acc0 = macq[0].a0;
      bus.acc1 = macq[0].a1;
      void'(macq.pop_front());
    end else begin
      bus.acc0 = rnd();
      bus.acc1 = rnd();
    end
  end

  // packet-level model and per-cycle comparison
  always @(negedge clk) begin
    if (started) begin
      pend = 0;
      foreach (bq[i]) pend += int'(bq[i].last);
      e_rdy = !rst && !rst_prev && (eq.size() + pend) < DEPTH;
      chk("in_ready", bus.in_ready, e_rdy);
      chk("out_valid", bus.out_valid, eq.size() != 0);
      chk("out_acc0", bus.out_acc0, eq.size() ? eq[0].a0 : 0);
      chk("out_acc1", bus.out_acc1, eq.size() ? eq[0].a1 : 0);
      chk("out_cnt", bus.out_cnt, eq.size() ? eq[0].c : 0);
      chk("out_sat", bus.out_sat, eq.size() ? eq[0].s : 0);
      if (bus.out_valid && bus.out_ready)
        got.push_back('{bus.out_acc0, bus.out_acc1, int'(bus.out_cnt), int'(bus.out_sat)});
      if (rst) begin
        bq.delete();
        eq.delete();
        run0 = 0; run1 = 0; mcnt = 0; msat = 0;
      end else begin
        if (eq.size() != 0 && bus.out_ready) void'(eq.pop_front());
        if (bq.size() != 0 && bq[0].due == tcyc) begin
          s0 = longint'(run0) + longint'($signed(bus.acc0));
          s1 = longint'(run1) + longint'($signed(bus.acc1));
`ifdef OLIMP_LANE_ACC_SAT_EN
          if (s0 > 64'sd2147483647) begin s0 = 64'sd2147483647; msat |= 1; end
          if (s0 < -64'sd2147483648) begin s0 = -64'sd2147483648; msat |= 1; end
          if (s1 > 64'sd2147483647) begin s1 = 64'sd2147483647; msat |= 2; end
          if (s1 < -64'sd2147483648) begin s1 = -64'sd2147483648; msat |= 2; end
`endif
          run0 = int'(s0);
          run1 = int'(s1);
          if (mcnt < (1 << CNT_W) - 1) mcnt++;
          if (bq[0].last) begin
            eq.push_back('{run0, run1, mcnt, msat});
            run0 = 0; run1 = 0; mcnt = 0; msat = 0;
          end
          void'(bq.pop_front());
        end
        if (bus.in_valid && e_rdy) bq.push_back('{tcyc + MAC_LAT, bus.in_last});
      end
      rst_prev = rst;
    end
  end

  task automatic beat(input bit l, input logic [31:0] a0, input logic [31:0] a1, output int c);
    int n = 0;
    bus.in_valid = 1;
    bus.in_last = l;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("beat_accept", bus.in_ready, 1);
    c = tcyc;
    if (bus.in_ready) macq.push_back('{tcyc + MAC_LAT, a0, a1});
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.in_last = 0;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got.size() < n && k < 200) begin
      k++;
      @(negedge clk);
    end
    chk("got_count", got.size(), n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, b, n;
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.out_ready = 1;
    repeat (2) @(posedge clk);
    started = 1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_cnt", bus.out_cnt, 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_rst", bus.in_ready, 1);

    b = got.size();
    beat(1, 100, -5, c);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("t1_latency", tcyc - c, MAC_LAT + 1);
    wait_got(b + 1);
    chk("t1_acc0", got[b].a0, 100);
    chk("t1_acc1", got[b].a1, 32'hFFFF_FFFB);
    chk("t1_cnt", got[b].c, 1);
    chk("t1_sat", got[b].s, 0);

    b = got.size();
    beat(0, 10, -1, c);
    beat(0, 20, -1, c);
    beat(0, 30, -1, c);
    beat(1, 40, -1, c);
    wait_got(b + 1);
    chk("t2_acc0", got[b].a0, 100);
    chk("t2_acc1", got[b].a1, 32'hFFFF_FFFC);
    chk("t2_cnt", got[b].c, 4);

    b = got.size();
    bus.out_ready = 0;
    beat(1, 1, 0, c);
    beat(1, 2, 0, c);
    @(negedge clk);
    chk("t3_blocked", bus.in_ready, 0);
    @(posedge clk);
    #1;
    fork
      beat(1, 3, 0, c);
      begin
        repeat (8) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    wait_got(b + 3);
    chk("t3_first", got[b].a0, 1);
    chk("t3_second", got[b + 1].a0, 2);
    chk("t3_third", got[b + 2].a0, 3);

    b = got.size();
    beat(0, 32'h7FFF_FFF0, 0, c);
    beat(1, 32'h0000_0020, 0, c);
    wait_got(b + 1);
`ifdef OLIMP_LANE_ACC_SAT_EN
    chk("t4_acc0", got[b].a0, 32'h7FFF_FFFF);
    chk("t4_sat", got[b].s, 1);
`else
    chk("t4_acc0", got[b].a0, 32'h8000_0010);
    chk("t4_sat", got[b].s, 0);
`endif

    b = got.size();
    beat(0, 5, 5, c);
    beat(1, 6, 6, c);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_entry", got.size(), b);
    beat(1, 7, 0, c);
    wait_got(b + 1);
    chk("t5_acc0", got[b].a0, 7);
    chk("t5_cnt", got[b].c, 1);

    b = got.size();
    bus.out_ready = 0;
    beat(1, 11, 0, c);
    beat(1, 12, 0, c);
    bus.out_ready = 1;
    wait_got(b + 2);
    chk("t6_first", got[b].a0, 11);
    chk("t6_second", got[b + 1].a0, 12);

    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = $urandom_range(0, 2) != 0;
      bus.in_last = $urandom_range(0, 3) == 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 499) == 0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.out_ready = 1;
    rst = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("drain_empty", bus.out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
